r_pow_coef_mac_t: RTL

//  Downstream consumer of r_pow_i_x_t. Accumulates acc[t] = SUM_k c_k * r[t]^(i+k) for T

---
 rtl/r_pow_coef_mac_t.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/r_pow_coef_mac_t.sv
// Polynomial-segment MAC: acc[t] = SUM_k c_k * r[t]^(i+k) over T lanes, one shared bytewise multiplier.
// Optional build macro RPOW_MAC_SKIP_ZERO_EN skips the coefficient multiply when c_k == 0.
module r_pow_coef_mac_t #(
  parameter string       FIELD         = "GF256",
  parameter string       PARAMETER_SET = "L1",
  parameter int unsigned M = (PARAMETER_SET == "L5") ? 480 : (PARAMETER_SET == "L3") ? 352 : 230,
  parameter int unsigned T = (PARAMETER_SET == "L5") ? 4 : 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [32*T-1:0]      i_r,
  input  logic [32*T-1:0]      i_r_pow,
  input  logic [$clog2(M):0]   i_n_terms,
  input  logic [31:0]          i_coef,
  input  logic                 i_coef_valid,
  output logic                 o_coef_ready,
  output logic [32*T-1:0]      o_acc,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned W  = 32 * T;
  localparam int unsigned NW = $clog2(M) + 1;
  localparam int unsigned LW = (T > 1) ? $clog2(T) : 1;
  localparam bit IsP251 = (FIELD == "P251");

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitCoef = 3'd1;
  localparam logic [2:0] StMulC     = 3'd2;
  localparam logic [2:0] StWaitC    = 3'd3;
  localparam logic [2:0] StMulR     = 3'd4;
  localparam logic [2:0] StWaitR    = 3'd5;
  localparam logic [2:0] StDone     = 3'd6;

  // One MSB-first Horner step per byte: p <- 2p + b*a in the selected field.
  function automatic logic [7:0] mul_step(input logic [7:0] p, input logic [7:0] a,
                                          input logic b);
    logic [8:0] s;
    logic [7:0] d;
    s = 9'd0;
    d = 8'd0;
    if (IsP251) begin
      s = {p, 1'b0};
      if (s >= 9'd251) s = s - 9'd251;
      s = s + {1'b0, (b ? a : 8'd0)};
      if (s >= 9'd251) s = s - 9'd251;
      d = s[7:0];
    end else begin
      d = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00) ^ (b ? a : 8'h00);
    end
    return d;
  endfunction

  function automatic logic [31:0] fadd32(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [8:0]  s;
    r = '0;
    s = 9'd0;
    for (int i = 0; i < 4; i++) begin
      if (IsP251) begin
        s = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]};
        if (s >= 9'd251) s = s - 9'd251;
        r[8*i +: 8] = s[7:0];
      end else begin
        r[8*i +: 8] = a[8*i +: 8] ^ b[8*i +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rot_lane(input logic [W-1:0] x);
    return {x[W-33:0], x[W-1 -: 32]};
  endfunction

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  r_q, r_d, cur_q, cur_d, acc_q, acc_d;
  logic [31:0]   coef_q, coef_d;
  logic [NW-1:0] n_q, n_d, term_cnt_q, term_cnt_d, term_inc;
  logic [LW-1:0] lane_cnt_q, lane_cnt_d;
  logic          done_q;
  logic [2:0]    entry_new, entry_cur;

  logic          mul_start, mul_busy_q, mul_done;
  logic [31:0]   mul_x, mul_y, mul_a_q, mul_b_q, mul_p_q, mul_p_nxt;
  logic [3:0]    mul_cnt_q;

  // Multiplier: 8 iterations; product is presented combinationally on the final one.
  always_comb begin
    mul_p_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      mul_p_nxt[8*i +: 8] = mul_step(mul_p_q[8*i +: 8], mul_a_q[8*i +: 8], mul_b_q[8*i+7]);
    end
  end

  assign mul_done = mul_busy_q && (mul_cnt_q == 4'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mul_busy_q <= 1'b0;
      mul_cnt_q  <= 4'd0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_p_q    <= '0;
    end else if (mul_start) begin
      mul_busy_q <= 1'b1;
      mul_cnt_q  <= 4'd8;
      mul_a_q    <= mul_x;
      mul_b_q    <= mul_y;
      mul_p_q    <= '0;
    end else if (mul_busy_q) begin
      mul_p_q   <= mul_p_nxt;
      mul_b_q   <= mul_b_q << 1;
      mul_cnt_q <= mul_cnt_q - 4'd1;
      if (mul_cnt_q == 4'd1) mul_busy_q <= 1'b0;
    end
  end

  always_comb begin
`ifdef RPOW_MAC_SKIP_ZERO_EN
    entry_new = (i_coef == 32'd0) ? StMulR : StMulC;
    entry_cur = (coef_q == 32'd0) ? StMulR : StMulC;
`else
    entry_new = StMulC;
    entry_cur = StMulC;
`endif
  end

  assign term_inc = term_cnt_q + NW'(1);

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    cur_d      = cur_q;
    acc_d      = acc_q;
    coef_d     = coef_q;
    n_d        = n_q;
    lane_cnt_d = lane_cnt_q;
    term_cnt_d = term_cnt_q;
    mul_start  = 1'b0;
    mul_x      = coef_q;
    mul_y      = cur_q[W-1 -: 32];
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          r_d        = i_r;
          cur_d      = i_r_pow;
          n_d        = i_n_terms;
          acc_d      = '0;
          coef_d     = '0;
          lane_cnt_d = '0;
          term_cnt_d = '0;
          state_d    = (i_n_terms == '0) ? StDone : StWaitCoef;
        end
      end
      StWaitCoef: begin
        if (i_coef_valid) begin
          coef_d     = i_coef;
          lane_cnt_d = '0;
          state_d    = entry_new;
        end
      end
      StMulC: begin
        mul_start = 1'b1;
        state_d   = StWaitC;
      end
      StWaitC: begin
        if (mul_done) begin
          acc_d[W-1 -: 32] = fadd32(acc_q[W-1 -: 32], mul_p_nxt);
          state_d          = StMulR;
        end
      end
      StMulR: begin
        mul_start = 1'b1;
        mul_x     = cur_q[W-1 -: 32];
        mul_y     = r_q[W-1 -: 32];
        state_d   = StWaitR;
      end
      StWaitR: begin
        if (mul_done) begin
          // Top lane done; rotate so the next lane is on top. T rotations restore order.
          cur_d = rot_lane({mul_p_nxt, cur_q[W-33:0]});
          r_d   = rot_lane(r_q);
          acc_d = rot_lane(acc_q);
          if (lane_cnt_q == LW'(T - 1)) begin
            lane_cnt_d = '0;
            term_cnt_d = term_inc;
            state_d    = (term_inc == n_q) ? StDone : StWaitCoef;
          end else begin
            lane_cnt_d = lane_cnt_q + LW'(1);
            state_d    = entry_cur;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      r_q        <= '0;
      cur_q      <= '0;
      acc_q      <= '0;
      coef_q     <= '0;
      n_q        <= '0;
      lane_cnt_q <= '0;
      term_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      cur_q      <= cur_d;
      acc_q      <= acc_d;
      coef_q     <= coef_d;
      n_q        <= n_d;
      lane_cnt_q <= lane_cnt_d;
      term_cnt_q <= term_cnt_d;
      done_q     <= (state_q == StDone);
    end
  end

  assign o_coef_ready = (state_q == StWaitCoef);
  assign o_busy       = (state_q != StIdle);
  assign o_done       = done_q;
  assign o_acc        = acc_q;

endmodule
